// File: rtl/mdu_unit_if.sv
// mdu_unit_if
//   Request/result bundle between the EX stage (master) and the multiply/divide
//   unit (slave).
//   Start  master->slave  request strobe, qualified by MDOp
//   MDOp   master->slave  operation code (4 bits)
//   SA     master->slave  rs operand
//   SB     master->slave  rt operand
//   Busy   slave->master  operation in flight
//   HI     slave->master  HI register
//   LO     slave->master  LO register
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       MDOp;
    logic [WIDTH-1:0] SA;
    logic [WIDTH-1:0] SB;
    logic             Busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, MDOp, SA, SB,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MDOp, SA, SB,
        output Busy, HI, LO
    );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit
//   Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
//   The full 2*WIDTH result is computed at the accept edge into a pending register.
//   It is then held back for MULT_CYCLES or DIV_CYCLES so the hazard unit sees the
//   architectural latency on Busy.
//   Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu, MDOp 7..10).
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mdu_unit_if slave: Start/MDOp/SA/SB in, Busy/HI/LO out
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    mdu_unit_if.slave   bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int W2      = 2 * WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [W2-1:0]      pend_r, pend_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;

    logic [WIDTH-1:0]   zero_s;
    logic [WIDTH-1:0]   one_s;
    logic [W2-1:0]      prod_sgn_s;
    logic [W2-1:0]      prod_uns_s;
    logic               sb_zero_s;
    logic [WIDTH-1:0]   abs_a_s;
    logic [WIDTH-1:0]   abs_b_s;
    logic [WIDTH-1:0]   udiv_b_s;
    logic [WIDTH-1:0]   sdiv_b_s;
    logic [WIDTH-1:0]   uq_s, ur_s;
    logic [WIDTH-1:0]   sq_mag_s, sr_mag_s;
    logic [WIDTH-1:0]   sq_s, sr_s;

    assign zero_s = {WIDTH{1'b0}};
    assign one_s  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Products: sign/zero-extend to 2*WIDTH so the truncated product is exact.
    assign prod_sgn_s = {{WIDTH{bus.SA[WIDTH-1]}}, bus.SA} * {{WIDTH{bus.SB[WIDTH-1]}}, bus.SB};
    assign prod_uns_s = {zero_s, bus.SA} * {zero_s, bus.SB};

    // Signed division is done on magnitudes; the most-negative dividend has magnitude
    // 2^(WIDTH-1) as an unsigned value, so the overflow case (MIN / -1) falls out as
    // quotient MIN, remainder 0 without a special case. A zero divisor is replaced by
    // one only to keep the divider defined; its result is never committed.
    assign sb_zero_s = (bus.SB == zero_s);
    assign abs_a_s   = bus.SA[WIDTH-1] ? (zero_s - bus.SA) : bus.SA;
    assign abs_b_s   = bus.SB[WIDTH-1] ? (zero_s - bus.SB) : bus.SB;
    assign udiv_b_s  = sb_zero_s ? one_s : bus.SB;
    assign sdiv_b_s  = sb_zero_s ? one_s : abs_b_s;
    assign uq_s      = bus.SA / udiv_b_s;
    assign ur_s      = bus.SA % udiv_b_s;
    assign sq_mag_s  = abs_a_s / sdiv_b_s;
    assign sr_mag_s  = abs_a_s % sdiv_b_s;
    assign sq_s      = (bus.SA[WIDTH-1] ^ bus.SB[WIDTH-1]) ? (zero_s - sq_mag_s) : sq_mag_s;
    assign sr_s      = bus.SA[WIDTH-1] ? (zero_s - sr_mag_s) : sr_mag_s;

`ifdef MDU_MADD_EN
    logic [W2-1:0] acc_s;
    assign acc_s = {hi_r, lo_r};
`endif

    // Next-state: accept in idle, count down while busy, commit on the last cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pend_s  = pend_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    case (bus.MDOp)
                        4'd1: begin
                            pend_s  = prod_sgn_s;
                            cnt_s   = CNT_W'(MULT_CYCLES);
                            state_s = ST_BUSY;
                        end
                        4'd2: begin
                            pend_s  = prod_uns_s;
                            cnt_s   = CNT_W'(MULT_CYCLES);
                            state_s = ST_BUSY;
                        end
                        4'd3: begin
                            // Divide by zero still occupies the unit but leaves HI/LO as is.
                            pend_s  = sb_zero_s ? {hi_r, lo_r} : {sr_s, sq_s};
                            cnt_s   = CNT_W'(DIV_CYCLES);
                            state_s = ST_BUSY;
                        end
                        4'd4: begin
                            pend_s  = sb_zero_s ? {hi_r, lo_r} : {ur_s, uq_s};
                            cnt_s   = CNT_W'(DIV_CYCLES);
                            state_s = ST_BUSY;
                        end
                        4'd5: begin
                            hi_s = bus.SA;
                        end
                        4'd6: begin
                            lo_s = bus.SA;
                        end
`ifdef MDU_MADD_EN
                        4'd7: begin
                            pend_s  = acc_s + prod_sgn_s;
                            cnt_s   = CNT_W'(MULT_CYCLES);
                            state_s = ST_BUSY;
                        end
                        4'd8: begin
                            pend_s  = acc_s + prod_uns_s;
                            cnt_s   = CNT_W'(MULT_CYCLES);
                            state_s = ST_BUSY;
                        end
                        4'd9: begin
                            pend_s  = acc_s - prod_sgn_s;
                            cnt_s   = CNT_W'(MULT_CYCLES);
                            state_s = ST_BUSY;
                        end
                        4'd10: begin
                            pend_s  = acc_s - prod_uns_s;
                            cnt_s   = CNT_W'(MULT_CYCLES);
                            state_s = ST_BUSY;
                        end
`endif
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Requests arriving here are dropped; the hazard unit stalls them.
                if (cnt_r == CNT_W'(1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                    hi_s    = pend_r[W2-1:WIDTH];
                    lo_s    = pend_r[WIDTH-1:0];
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and architectural registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            pend_r  <= {W2{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

    assign bus.Busy = (state_r == ST_BUSY);
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit
//   Self-checking bench for mdu_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10):
//   a table of directed vectors, hand-written multi-cycle sequences, and randomized
//   operations compared against a 64-bit arithmetic reference model.
module tb_mdu_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset_n;

    mdu_unit_if #(.WIDTH(W)) bus ();

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bench-side copy of the architectural HI/LO state.
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    typedef struct {
        string        name;
        logic [W-1:0] pre_hi;
        logic [W-1:0] pre_lo;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           exp_cyc;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operation's definition.
    function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] hi, input logic [W-1:0] lo,
                                   output int cyc, output logic [W-1:0] nh, output logic [W-1:0] nl);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        cyc = 0;
        res = {hi, lo};
        case (op)
            4'd1: begin cyc = MC; res = sa * sb; end
            4'd2: begin cyc = MC; res = ua * ub; end
            4'd3: begin
                cyc = DC;
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                cyc = DC;
                if (b != 32'd0) begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
            4'd5: res = {a, lo};
            4'd6: res = {hi, a};
`ifdef MDU_MADD_EN
            4'd7:  begin cyc = MC; res = {hi, lo} + 64'(sa * sb); end
            4'd8:  begin cyc = MC; res = {hi, lo} + 64'(ua * ub); end
            4'd9:  begin cyc = MC; res = {hi, lo} - 64'(sa * sb); end
            4'd10: begin cyc = MC; res = {hi, lo} - 64'(ua * ub); end
`endif
            default: res = {hi, lo};
        endcase
        nh = res[63:32];
        nl = res[31:0];
    endfunction

    // Present one request for one edge, then scramble operands (they need not be held).
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.SA    = a;
        bus.SB    = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.MDOp  = 4'd0;
        bus.SA    = $urandom;
        bus.SB    = $urandom;
    endtask

    // Issue and count busy cycles; hold_ok drops if HI/LO move during the busy window.
    task automatic exec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int cyc, output logic hold_ok);
        issue(op, a, b);
        cyc     = 0;
        hold_ok = 1'b1;
        while (bus.Busy && cyc < 100) begin
            if (bus.HI !== m_hi || bus.LO !== m_lo) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc, ecyc;
        logic hold_ok;
        logic [W-1:0] nh, nl;
        ref_op(op, a, b, m_hi, m_lo, ecyc, nh, nl);
        exec(op, a, b, cyc, hold_ok);
        chk({name, " cycles"}, 64'(cyc), 64'(ecyc));
        chk({name, " hold"}, {63'd0, hold_ok}, 64'd1);
        chk({name, " hilo"}, {bus.HI, bus.LO}, {nh, nl});
        m_hi = nh;
        m_lo = nl;
    endtask

    initial begin
        int cyc;
        logic hold_ok;
        logic [3:0] rop;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{"mult_neg2x3",  32'h0,  32'h0, 4'd1, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{"multu_fffex3", 32'h0,  32'h0, 4'd2, 32'hFFFFFFFE, 32'd3, MC, 32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{"div_m7_2",     32'h0,  32'h0, 4'd3, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"div_ovf",      32'h9,  32'h9, 4'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0, 32'h80000000};
        vecs[4]  = '{"div_zero",     32'h11, 32'h22, 4'd3, 32'd5, 32'd0, DC, 32'h11, 32'h22};
        vecs[5]  = '{"divu_100_7",   32'h0,  32'h0, 4'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14};
        vecs[6]  = '{"divu_zero",    32'h33, 32'h44, 4'd4, 32'hFFFFFFFF, 32'd0, DC, 32'h33, 32'h44};
        vecs[7]  = '{"mthi",         32'h0,  32'h0, 4'd5, 32'h55, 32'd0, 0, 32'h55, 32'h0};
        vecs[8]  = '{"mtlo",         32'h1,  32'h2, 4'd6, 32'h66, 32'd0, 0, 32'h1, 32'h66};
        vecs[9]  = '{"op_none",      32'h7,  32'h8, 4'd0, 32'h1234, 32'd5, 0, 32'h7, 32'h8};
        vecs[10] = '{"op_undef",     32'h7,  32'h8, 4'd15, 32'h1234, 32'd5, 0, 32'h7, 32'h8};
        vecs[11] = '{"div_7_m2",     32'h0,  32'h0, 4'd3, 32'd7, 32'hFFFFFFFE, DC, 32'h1, 32'hFFFFFFFD};
`ifdef MDU_MADD_EN
        vecs[12] = '{"madd_carry",   32'h0,  32'hFFFFFFFF, 4'd7, 32'd1, 32'd1, MC, 32'h1, 32'h0};
`else
        vecs[12] = '{"op7_disabled", 32'h0,  32'hFFFFFFFF, 4'd7, 32'd1, 32'd1, 0, 32'h0, 32'hFFFFFFFF};
`endif

        reset_n   = 1'b0;
        bus.Start = 1'b0;
        bus.MDOp  = 4'd0;
        bus.SA    = '0;
        bus.SB    = '0;
        m_hi      = '0;
        m_lo      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {63'd0, bus.Busy}, 64'd0);
        chk("reset hilo", {bus.HI, bus.LO}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            run_op("preload_hi", 4'd5, vecs[i].pre_hi, 32'd0);
            run_op("preload_lo", 4'd6, vecs[i].pre_lo, 32'd0);
            exec(vecs[i].op, vecs[i].a, vecs[i].b, cyc, hold_ok);
            chk({vecs[i].name, " cycles"}, 64'(cyc), 64'(vecs[i].exp_cyc));
            chk({vecs[i].name, " hold"}, {63'd0, hold_ok}, 64'd1);
            chk({vecs[i].name, " hilo"}, {bus.HI, bus.LO}, {vecs[i].exp_hi, vecs[i].exp_lo});
            m_hi = vecs[i].exp_hi;
            m_lo = vecs[i].exp_lo;
        end

        // Requests while busy are dropped: mult and mthi during a divu.
        run_op("seq_pre_hi", 4'd5, 32'hAA, 32'd0);
        run_op("seq_pre_lo", 4'd6, 32'hBB, 32'd0);
        issue(4'd4, 32'd100, 32'd7);
        @(negedge clk);
        bus.Start = 1'b1; bus.MDOp = 4'd1; bus.SA = 32'd9; bus.SB = 32'd9;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(negedge clk);
        bus.Start = 1'b1; bus.MDOp = 4'd5; bus.SA = 32'h55;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.MDOp = 4'd0;
        chk("busy mthi ignored", {bus.HI, bus.LO}, {32'hAA, 32'hBB});
        cyc = 2;
        while (bus.Busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy ignore cycles", 64'(cyc), 64'(DC));
        chk("busy ignore result", {bus.HI, bus.LO}, {32'd2, 32'd14});
        repeat (8) @(posedge clk);
        #1;
        chk("no late mult", {31'd0, bus.Busy, bus.HI}, {32'd0, 32'd2});
        chk("no late mult lo", {32'd0, bus.LO}, 64'd14);
        m_hi = 32'd2;
        m_lo = 32'd14;

        // Asynchronous reset in the middle of a divide.
        issue(4'd3, 32'd1000, 32'd3);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset busy", {63'd0, bus.Busy}, 64'd0);
        chk("midreset hilo", {bus.HI, bus.LO}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("after reset idle", {31'd0, bus.Busy, bus.HI, bus.LO}, 65'd0);
        run_op("mult after reset", 4'd1, 32'd12345, 32'hFFFFFF00);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 11));
            if (rop == 4'd11) rop = 4'd13;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
